// File: rtl/shift_sub_divider_if.sv
// Handshake/operand bundle for shift_sub_divider.
//   run           : debounced start level (rising edge starts a division)
//   dividend_i    : dividend, sampled on the start cycle
//   divisor_i     : divisor, sampled on the start cycle
//   quotient_o    : registered quotient
//   remainder_o   : registered remainder
//   busy_o        : division in progress
//   done_o        : result valid, held until run drops
//   div_by_zero_o : result came from a zero divisor
// master drives run/operands; slave is the divider.
interface shift_sub_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             run;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;

  modport master (
    output run, dividend_i, divisor_i,
    input  quotient_o, remainder_o, busy_o, done_o, div_by_zero_o
  );

  modport slave (
    input  run, dividend_i, divisor_i,
    output quotient_o, remainder_o, busy_o, done_o, div_by_zero_o
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : synchronous active-high reset, clears all state and outputs
//   bus   : shift_sub_divider_if.slave (run, operands, results, status)
// Build option: define DIV_SIGNED_EN for two's-complement operands
// (magnitude division with sign fix-up on the result write, truncating toward zero).
module shift_sub_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic                Clk,
  input logic                Reset,
  shift_sub_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic              armed_q, armed_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic              start;
  logic [WIDTH-1:0]  dvd_mag, dvs_mag;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH-1:0]  q_next, r_next;
  logic [WIDTH-1:0]  q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag = bus.dividend_i[WIDTH-1] ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign dvs_mag = bus.divisor_i[WIDTH-1]  ? (~bus.divisor_i + 1'b1)  : bus.divisor_i;
  assign q_fix   = neg_quot_q ? (~q_next + 1'b1) : q_next;
  assign r_fix   = neg_rem_q  ? (~r_next + 1'b1) : r_next;
`else
  assign dvd_mag = bus.dividend_i;
  assign dvs_mag = bus.divisor_i;
  assign q_fix   = q_next;
  assign r_fix   = r_next;
`endif

  // A run level held through Reset must not look like a fresh press, so a start
  // is only accepted once run has been seen low since the last Reset.
  assign start = bus.run & ~run_q & armed_q;

  // Before the final step R < 2^(WIDTH-1), so dropping R's MSB in the shift is lossless.
  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {1'b0, d_q};
  assign r_next  = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
  assign q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~bus.run;
    cnt_d   = cnt_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bus.divisor_i == '0) begin
            state_d = StHold;
            quot_d  = '1;
            rem_d   = bus.dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = StCalc;
            d_d     = dvs_mag;
            q_d     = dvd_mag;
            r_d     = '0;
            cnt_d   = '0;
`ifdef DIV_SIGNED_EN
            neg_quot_d = bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1];
            neg_rem_d  = bus.dividend_i[WIDTH-1];
`endif
          end
        end
      end
      StCalc: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StHold;
          quot_d  = q_fix;
          rem_d   = r_fix;
        end
      end
      StHold: begin
        if (!bus.run) begin
          state_d = StIdle;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= bus.run;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign bus.quotient_o    = quot_q;
  assign bus.remainder_o   = rem_q;
  assign bus.busy_o        = (state_q == StCalc);
  assign bus.done_o        = (state_q == StHold);
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
module tb_shift_sub_divider;
  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  shift_sub_divider_if #(.WIDTH(W)) bus ();

  shift_sub_divider #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic division.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sa;
    int sb;
    dz = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(1 << (W - 1)) && sb == -1) begin
        q = W'(1 << (W - 1));
        r = '0;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
`endif
    end
  endfunction

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                        input string name);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           lat;
    int           extra;
    model(a, b, eq, er, edz);
    lat = edz ? 1 : W + 1;
    @(posedge clk); #1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.run        = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (toggle) begin
        bus.dividend_i = W'($urandom);
        bus.divisor_i  = W'($urandom);
      end
      checks++;
      if ({bus.busy_o, bus.done_o} !== {(!edz && k < lat), (k == lat)}) begin
        errors++;
        $display("FAIL %s status clk%0d: busy/done=%b%b required %b%b", name, k,
                 bus.busy_o, bus.done_o, (!edz && k < lat), (k == lat));
      end
      if (k < lat) begin
        checks++;
        if ({bus.quotient_o, bus.remainder_o} !== {prev_q, prev_r}) begin
          errors++;
          $display("FAIL %s held result clk%0d: q=%h r=%h required q=%h r=%h", name, k,
                   bus.quotient_o, bus.remainder_o, prev_q, prev_r);
        end
      end
    end
    checks++;
    if ({bus.quotient_o, bus.remainder_o, bus.div_by_zero_o} !== {eq, er, edz}) begin
      errors++;
      $display("FAIL %s %h/%h result: q=%h r=%h dz=%b required q=%h r=%h dz=%b", name, a, b,
               bus.quotient_o, bus.remainder_o, bus.div_by_zero_o, eq, er, edz);
    end
    extra = $urandom_range(0, 2);
    for (int k = 0; k < extra; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.busy_o, bus.done_o, bus.div_by_zero_o} !== {1'b0, 1'b1, edz}) begin
        errors++;
        $display("FAIL %s hold: busy/done/dz=%b%b%b required 01%b", name,
                 bus.busy_o, bus.done_o, bus.div_by_zero_o, edz);
      end
    end
    bus.run = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.quotient_o, bus.remainder_o}
        !== {3'b000, eq, er}) begin
      errors++;
      $display("FAIL %s release: b/d/z=%b%b%b q=%h r=%h required 000 q=%h r=%h", name,
               bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.quotient_o, bus.remainder_o,
               eq, er);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.quotient_o, bus.remainder_o, bus.busy_o, bus.done_o, bus.div_by_zero_o} !== '0)
    begin
      errors++;
      $display("FAIL %s: q=%h r=%h b/d/z=%b%b%b required all 0", name, bus.quotient_o,
               bus.remainder_o, bus.busy_o, bus.done_o, bus.div_by_zero_o);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.dividend_i = W'($urandom);
    bus.divisor_i  = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("after reset");
    prev_q = '0;
    prev_r = '0;
  endtask

  task automatic test_directed();
    do_div(8'd200, 8'd7, 1'b0, "200/7");
  endtask

  task automatic test_back_to_back();
    do_div(8'd255, 8'd16, 1'b0, "255/16");
    do_div(8'd0, 8'd9, 1'b0, "0/9");
  endtask

  task automatic test_div_zero();
    do_div(8'd5, 8'd0, 1'b0, "5/0");
  endtask

  task automatic test_reset_mid_calc();
    @(posedge clk); #1;
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 8'd7;
    bus.run        = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL mid-calc busy clk%0d: busy=%b required 1", k, bus.busy_o);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset mid-calc");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check_all_zero("run held over reset");
    end
    bus.run = 1'b0;
    prev_q = '0;
    prev_r = '0;
    do_div(8'd200, 8'd7, 1'b1, "200/7 toggled");
  endtask

  task automatic test_signed();
`ifdef DIV_SIGNED_EN
    do_div(8'h9C, 8'h07, 1'b0, "-100/7");
    do_div(8'h80, 8'hFF, 1'b0, "-128/-1");
    do_div(8'h64, 8'hF9, 1'b0, "100/-7");
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      do_div(a, b, bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_div_zero();
    test_reset_mid_calc();
    test_signed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
